// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// State encoding is fixed so the core-side debug view can decode it.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        DONE  = ST_DONE
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_VID = 1'b1;

    // Wide enough for MEM_LAT and STARVE_MAX up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant decision: CPU wins ties unless port 1 has been
// passed over STARVE_MAX times in a row.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic             cpu_req,
    input  logic             vid_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant,
    output logic             grant_valid
);

    always_comb begin
        grant_valid = cpu_req | vid_req;
        grant       = PORT_CPU;
        if (vid_req && (!cpu_req || (starve_cnt == CNT_W'(STARVE_MAX)))) begin
            grant = PORT_VID;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory access controller sharing one fixed-latency port between the CPU
// (read/write) and a read-only video/debug port.
//
//   state | meaning
//   IDLE  | arbitrate; latch winner's address/we/wdata
//   ISSUE | single-cycle mem_en strobe
//   WAIT  | MEM_LAT cycles; capture mem_rdata on the last one
//   DONE  | one-cycle ready pulse to the granted port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic              gnt_port;
    logic              gnt_valid;
    logic              gnt_q;
    logic              we_q;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vid_rdata_q;

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .cpu_req     (cpu_req),
        .vid_req     (vid_req),
        .starve_cnt  (starve_cnt),
        .grant       (gnt_port),
        .grant_valid (gnt_valid)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_q ? DONE : WAIT;
            WAIT:    if (wait_cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            gnt_q       <= PORT_CPU;
            we_q        <= 1'b0;
            starve_cnt  <= '0;
            wait_cnt    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        gnt_q <= gnt_port;
                        if (gnt_port == PORT_CPU) begin
                            we_q    <= cpu_we;
                            addr_q  <= cpu_addr;
                            wdata_q <= cpu_wdata;
                            if (vid_req && (starve_cnt < CNT_W'(STARVE_MAX))) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else begin
                            // port 1 can never write
                            we_q       <= 1'b0;
                            addr_q     <= vid_addr;
                            wdata_q    <= '0;
                            starve_cnt <= '0;
                        end
                    end
                end
                ISSUE: wait_cnt <= CNT_W'(MEM_LAT - 1);
                WAIT: begin
                    if (wait_cnt == '0) begin
                        if (gnt_q == PORT_CPU) cpu_rdata_q <= mem_rdata;
                        else                   vid_rdata_q <= mem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ready = (state == DONE) && (gnt_q == PORT_CPU);
    assign vid_ready = (state == DONE) && (gnt_q == PORT_VID);
    assign cpu_rdata = cpu_rdata_q;
    assign vid_rdata = vid_rdata_q;
    assign busy      = (state != IDLE);

endmodule
